// File: rtl/code_pack_sched.sv
// code_pack_sched
// Frame-level sequencer between the input pixel FIFO, the codec and the
// output byte FIFO. On start it pulls PIX_COUNT pixel bytes one at a time,
// hands each to the codec, and packs the returned variable-length code
// words MSB-first into bytes for the output FIFO. At frame end the last
// partial byte is zero-padded and done pulses.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   start               one-cycle pulse, begins a frame (ignored while busy)
//   empty_in            input FIFO empty
//   fifo_in_dout        input FIFO data, valid the cycle after fifo_in_rd
//   fifo_in_rd          input FIFO read strobe
//   code_en, data_in    one-cycle pixel strobe and pixel byte to the codec
//   en_out              codec code-word valid
//   cod_32, len_32      right-aligned code word and its length (0..32)
//   full_out            output FIFO full
//   fifo_out_din        packed byte to the output FIFO
//   fifo_out_wr         output FIFO write strobe
//   busy                high from accepted start until done
//   done                one-cycle pulse at frame completion
//   err                 sticky flag: a code length above 32 was seen
module code_pack_sched #(
  parameter int unsigned PIX_COUNT = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        empty_in,
  input  logic [7:0]  fifo_in_dout,
  output logic        fifo_in_rd,
  output logic        code_en,
  output logic [7:0]  data_in,
  input  logic        en_out,
  input  logic [31:0] cod_32,
  input  logic [5:0]  len_32,
  input  logic        full_out,
  output logic [7:0]  fifo_out_din,
  output logic        fifo_out_wr,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_ISSUE,
    S_WAIT_CODE,
    S_DRAIN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;

  // acc is left-aligned: the next bit to be emitted is acc[39], and every
  // bit below position 39-bitcnt is zero, so a flush byte is already padded.
  logic [39:0] acc;
  logic [5:0]  bitcnt;
  // One bit wider than 24 so the full 2^24-pixel frame size is representable.
  logic [24:0] pix_left;
  logic [7:0]  pix_reg;
  logic        err_q;

  logic [5:0]  code_len;
  logic [31:0] code_mask;
  logic [5:0]  code_shift;
  logic [39:0] code_bits;

  // Clamp the code length to 32, keep only its low L bits and place them
  // directly below the bits already held. With bitcnt<=7 the shift is >=1.
  always_comb begin
    code_len   = (len_32 > 6'd32) ? 6'd32 : len_32;
    code_mask  = (code_len == 6'd32) ? 32'hFFFF_FFFF
                                     : ((32'd1 << code_len) - 32'd1);
    code_shift = 6'd40 - bitcnt - code_len;
    code_bits  = {8'd0, cod_32 & code_mask} << code_shift;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and strobe decode. Strobes are combinational on state so
  // fifo_in_rd can never fire into an empty FIFO and fifo_out_wr never into
  // a full one.
  always_comb begin
    state_nxt    = state;
    fifo_in_rd   = 1'b0;
    code_en      = 1'b0;
    data_in      = 8'd0;
    fifo_out_wr  = 1'b0;
    fifo_out_din = 8'd0;
    done         = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (!empty_in) begin
          fifo_in_rd = 1'b1;
          state_nxt  = S_LATCH;
        end
      end
      S_LATCH: begin
        state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        code_en   = 1'b1;
        data_in   = pix_reg;
        state_nxt = S_WAIT_CODE;
      end
      S_WAIT_CODE: begin
        if (en_out) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (bitcnt >= 6'd8) begin
          if (!full_out) begin
            fifo_out_wr  = 1'b1;
            fifo_out_din = acc[39:32];
          end
        end else if (pix_left != 25'd0) begin
          state_nxt = S_FETCH;
        end else begin
          state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (bitcnt == 6'd0) begin
          state_nxt = S_DONE;
        end else if (!full_out) begin
          fifo_out_wr  = 1'b1;
          fifo_out_din = acc[39:32];
          state_nxt    = S_DONE;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE) && (state != S_DONE);
  assign err  = err_q;

  // Datapath registers: pixel counter, pixel latch, bit accumulator and the
  // sticky length error. Byte removal follows the write strobe exactly so a
  // stalled output FIFO leaves the accumulator untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= 40'd0;
      bitcnt   <= 6'd0;
      pix_left <= 25'd0;
      pix_reg  <= 8'd0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            pix_left <= 25'(PIX_COUNT);
            acc      <= 40'd0;
            bitcnt   <= 6'd0;
            err_q    <= 1'b0;
          end
        end
        S_LATCH: begin
          pix_reg <= fifo_in_dout;
        end
        S_ISSUE: begin
          pix_left <= pix_left - 25'd1;
        end
        S_WAIT_CODE: begin
          if (en_out) begin
            acc    <= acc | code_bits;
            bitcnt <= bitcnt + code_len;
            if (len_32 > 6'd32) err_q <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (fifo_out_wr) begin
            acc    <= {acc[31:0], 8'd0};
            bitcnt <= bitcnt - 6'd8;
          end
        end
        S_FLUSH: begin
          if (fifo_out_wr) begin
            acc    <= 40'd0;
            bitcnt <= 6'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
